strided_rd_sched: RTL and testbench

STRIDED_RD_SCHED -- requirements
Module: strided_rd_sched

---
 rtl/strided_rd_sched_pkg.sv | 9 +
 rtl/strided_lane_addr.sv | 33 +++
 rtl/strided_rd_sched.sv | 127 ++++++++++++
 tb/tb_strided_rd_sched.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/strided_rd_sched_pkg.sv
// strided_rd_sched_pkg: shared FSM states, dshape field layout and channel wrap shift.
package strided_rd_sched_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_READ, S_DONE} state_t;
  localparam int C_LSB      = 0;
  localparam int H_LSB      = 16;
  localparam int W_LSB      = 32;
  localparam int FLD_W      = 16;
  localparam int WRAP_SHIFT = 6;
endpackage

// File: rtl/strided_lane_addr.sv
// strided_lane_addr: one read lane; tracks bank (x mod N_BUF_X) and the column-block base address incrementally.
module strided_lane_addr #(
  parameter int N_BUF_X    = 5,
  parameter int B_BUF_ADDR = 9,
  parameter int B_BANK     = 3,
  parameter int LANE       = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_init,
  input  logic                  i_adv,
  input  logic [B_BUF_ADDR-1:0] i_stride,
  input  logic [B_BUF_ADDR-1:0] i_row_off,
  output logic [B_BANK-1:0]     o_bank,
  output logic [B_BUF_ADDR-1:0] o_addr
);
  logic [B_BANK-1:0]     r_rem;
  logic [B_BUF_ADDR-1:0] r_qbase;
  logic                  w_wrap;
  assign w_wrap = r_rem == B_BANK'(N_BUF_X - 1);
  // lanes start at x=LANE < N_BUF_X, so the initial quotient is always zero
  always_ff @(posedge clk) begin
    if (!rstn || i_init) begin
      r_rem   <= B_BANK'(LANE);
      r_qbase <= '0;
    end else if (i_adv) begin
      r_rem   <= w_wrap ? '0 : r_rem + 1'b1;
      r_qbase <= w_wrap ? r_qbase + i_stride : r_qbase;
    end
  end
  assign o_bank = r_rem;
  assign o_addr = r_qbase + i_row_off;
endmodule

// File: rtl/strided_rd_sched.sv
// strided_rd_sched: clear/load/strided-read job scheduler over N_BUF_X banks with N_DSP lanes.
// Optional STRIDED_RD_SCHED_STALL_CNT_EN adds a saturating stall_cnt output.
module strided_rd_sched
  import strided_rd_sched_pkg::*;
#(
  parameter int N_BUF_X    = 5,
  parameter int N_DSP      = 3,
  parameter int B_BUF_ADDR = 9,
  parameter int B_DSHAPE   = 48,
  parameter int B_COORD    = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [B_DSHAPE-1:0]           dshape,
  input  logic                          start,
  input  logic                          abort,
  output logic                          clr,
  input  logic                          ld_done,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [N_BUF_X-1:0]            rd_bank_en,
  output logic [N_BUF_X*B_BUF_ADDR-1:0] rd_addr,
  output logic [3*B_COORD-1:0]          rd_coord,
  output logic                          busy,
  output logic                          done,
  output logic                          err
`ifdef STRIDED_RD_SCHED_STALL_CNT_EN
  ,output logic [31:0]                  stall_cnt
`endif
);
  localparam int B_BANK = N_BUF_X > 1 ? $clog2(N_BUF_X) : 1;
  state_t r_state, w_next;
  logic [FLD_W-1:0]      r_nwc, r_h, r_w, r_cw, r_y, r_x0;
  logic [FLD_W-1:0]      w_c, w_h, w_w;
  logic [B_BUF_ADDR-1:0] r_stride, r_yoff, w_row_off;
  logic                  r_err, w_bad, w_fire, w_cw_last, w_y_last, w_x_last, w_adv, w_last;
  logic [B_BANK-1:0]     w_bank [N_DSP];
  logic [B_BUF_ADDR-1:0] w_laddr [N_DSP];
  assign w_c       = dshape[C_LSB+:FLD_W];
  assign w_h       = dshape[H_LSB+:FLD_W];
  assign w_w       = dshape[W_LSB+:FLD_W];
  assign w_bad     = (w_c >> WRAP_SHIFT) == '0 || w_h == '0 || w_w < FLD_W'(N_DSP);
  assign w_fire    = r_state == S_READ && rd_ready;
  assign w_cw_last = r_cw == r_nwc - 1'b1;
  assign w_y_last  = r_y == r_h - 1'b1;
  assign w_x_last  = r_x0 == r_w - FLD_W'(N_DSP);
  assign w_adv     = w_fire && w_cw_last && w_y_last;
  assign w_last    = w_adv && w_x_last;
  assign w_row_off = r_yoff + B_BUF_ADDR'(r_cw);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? (w_bad ? S_DONE : S_CLR) : S_IDLE;
      S_CLR:   w_next = S_LOAD;
      S_LOAD:  w_next = ld_done ? S_READ : S_LOAD;
      S_READ:  w_next = w_last ? S_DONE : S_READ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort && r_state != S_IDLE) w_next = S_IDLE;
  end
  always_ff @(posedge clk) r_state <= !rstn ? S_IDLE : w_next;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_nwc    <= '0;
      r_h      <= '0;
      r_w      <= '0;
      r_err    <= 1'b0;
      r_stride <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_nwc <= w_c >> WRAP_SHIFT;
      r_h   <= w_h;
      r_w   <= w_w;
      r_err <= w_bad;
    end else if (r_state == S_CLR) begin
      r_stride <= B_BUF_ADDR'(r_nwc * r_h);
    end
  end
  // cw innermost, then y, then x0; y's address term n_wrap_c*y kept as a running sum
  always_ff @(posedge clk) begin
    if (!rstn || r_state != S_READ) begin
      r_cw   <= '0;
      r_y    <= '0;
      r_x0   <= '0;
      r_yoff <= '0;
    end else if (w_fire) begin
      r_cw <= w_cw_last ? '0 : r_cw + 1'b1;
      if (w_cw_last) begin
        r_y    <= w_y_last ? '0 : r_y + 1'b1;
        r_yoff <= w_y_last ? '0 : r_yoff + B_BUF_ADDR'(r_nwc);
        r_x0   <= w_y_last ? r_x0 + 1'b1 : r_x0;
      end
    end
  end
  for (genvar k = 0; k < N_DSP; k++) begin : g_lane
    strided_lane_addr #(
      .N_BUF_X(N_BUF_X), .B_BUF_ADDR(B_BUF_ADDR), .B_BANK(B_BANK), .LANE(k)
    ) u_lane (
      .clk(clk), .rstn(rstn), .i_init(r_state != S_READ), .i_adv(w_adv),
      .i_stride(r_stride), .i_row_off(w_row_off), .o_bank(w_bank[k]), .o_addr(w_laddr[k])
    );
  end
  always_comb begin
    rd_bank_en = '0;
    rd_addr    = '0;
    if (r_state == S_READ)
      for (int k = 0; k < N_DSP; k++) begin
        rd_bank_en[w_bank[k]] = 1'b1;
        rd_addr[int'(w_bank[k])*B_BUF_ADDR+:B_BUF_ADDR] = w_laddr[k];
      end
  end
  assign rd_valid = r_state == S_READ;
  assign rd_coord = rd_valid ? {r_cw[B_COORD-1:0], r_y[B_COORD-1:0], r_x0[B_COORD-1:0]} : '0;
  assign clr      = r_state == S_CLR;
  assign done     = r_state == S_DONE;
  assign busy     = r_state != S_IDLE;
  assign err      = r_err;
`ifdef STRIDED_RD_SCHED_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  always_ff @(posedge clk) begin
    if (!rstn || (r_state == S_IDLE && start)) r_stall_cnt <= '0;
    else if (r_state == S_READ && !rd_ready && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
  end
  assign stall_cnt = r_stall_cnt;
`else
`endif
endmodule

// File: tb/tb_strided_rd_sched.sv
// tb_strided_rd_sched: table-driven job runs with a queue scoreboard of expected read beats.
module tb_strided_rd_sched;
  localparam int NB = 5, ND = 3, BA = 9, BD = 48, BC = 8;
  logic clk = 0, rstn, start, abort, ld_done, rd_ready;
  logic [BD-1:0] dshape;
  logic clr, rd_valid, busy, done, err;
  logic [NB-1:0] rd_bank_en;
  logic [NB*BA-1:0] rd_addr;
  logic [3*BC-1:0] rd_coord;
`ifdef STRIDED_RD_SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  always #5 clk = ~clk;
  strided_rd_sched #(.N_BUF_X(NB), .N_DSP(ND), .B_BUF_ADDR(BA), .B_DSHAPE(BD), .B_COORD(BC)) dut (
    .clk(clk), .rstn(rstn), .dshape(dshape), .start(start), .abort(abort), .clr(clr),
    .ld_done(ld_done), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_bank_en(rd_bank_en),
    .rd_addr(rd_addr), .rd_coord(rd_coord), .busy(busy), .done(done), .err(err)
`ifdef STRIDED_RD_SCHED_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  typedef struct packed {
    logic [NB-1:0]    en;
    logic [NB*BA-1:0] addr;
    logic [3*BC-1:0]  coord;
  } beat_t;
  typedef struct {
    int c, h, w;
    bit rnd;
    int abort_at;
    bit poke;
    bit exp_err;
  } vec_t;
  beat_t q[$];
  beat_t got[$];
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic beat_t model(input int c, input int h, input int cw, input int y, input int x0);
    beat_t b;
    int nwc, x, bk, a;
    b = '0;
    nwc = c >> 6;
    for (int k = 0; k < ND; k++) begin
      x = x0 + k;
      bk = x % NB;
      a = nwc * (y + h * (x / NB)) + cw;
      b.en[bk] = 1'b1;
      b.addr[bk*BA+:BA] = a[BA-1:0];
    end
    b.coord = {cw[BC-1:0], y[BC-1:0], x0[BC-1:0]};
    return b;
  endfunction
  task automatic run_job(input vec_t v);
    int beats = 0, clrs = 0, dones = 0, valids = 0, stalls = 0, ld_cnt = 0, exp_beats = 0, after = 0;
    bit fin = 0, clr_seen = 0, prev_stall = 0, poked = 0, aborted = 0;
    beat_t prev, cur, e;
    q.delete();
    got.delete();
    if (!v.exp_err)
      for (int x0 = 0; x0 <= v.w - ND; x0++)
        for (int y = 0; y < v.h; y++)
          for (int cw = 0; cw < (v.c >> 6); cw++) begin
            q.push_back(model(v.c, v.h, cw, y, x0));
            exp_beats++;
          end
    @(negedge clk);
    dshape = {16'(v.w), 16'(v.h), 16'(v.c)};
    ld_done = 0;
    rd_ready = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      if (aborted) begin
        after++;
        if (after == 1) begin
          chk("abort_valid", rd_valid, 0);
          chk("abort_busy", busy, 0);
        end
        if (after == 6) fin = 1;
      end
      if (clr) begin clrs++; clr_seen = 1; end
      if (done) begin
        dones++;
        chk("err_at_done", err, v.exp_err);
        if (!aborted) fin = 1;
      end
      cur = {rd_bank_en, rd_addr, rd_coord};
      if (prev_stall) chk("stall_hold", {rd_valid, cur}, {1'b1, prev});
      if (rd_valid) valids++;
      if (clr_seen) ld_cnt++;
      ld_done = ld_cnt >= 3;
      rd_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = rd_valid && !rd_ready;
      prev = cur;
      if (rd_valid && !rd_ready) stalls++;
      if (rd_valid && rd_ready) begin
        if (q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = q.pop_front();
          chk("beat", cur, e);
        end
        got.push_back(cur);
        beats++;
      end
      if (v.poke && beats == 5 && !poked) begin
        start = 1;
        dshape = {16'd3, 16'd1, 16'd64};
        poked = 1;
      end else start = 0;
      if (beats == v.abort_at && !aborted) begin
        abort = 1;
        aborted = 1;
      end else abort = 0;
      @(negedge clk);
    end
    start = 0;
    abort = 0;
    if (!fin) chk("timeout", 0, 1);
    chk("clr_pulses", clrs, v.exp_err ? 0 : 1);
    chk("done_pulses", dones, v.abort_at >= 0 ? 0 : 1);
    if (v.exp_err) chk("valid_cycles", valids, 0);
    if (v.abort_at < 0) begin
      chk("beats", beats, exp_beats);
      chk("queue_empty", q.size(), 0);
      chk("err_hold", err, v.exp_err);
      chk("idle_done", {busy, done, rd_valid}, 0);
`ifdef STRIDED_RD_SCHED_STALL_CNT_EN
      if (!v.exp_err) chk("stall_cnt", stall_cnt, stalls);
`endif
    end
    ld_done = 0;
    rd_ready = 0;
  endtask
  vec_t vecs[10];
  initial begin
    rstn = 0; start = 0; abort = 0; ld_done = 0; rd_ready = 0; dshape = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {clr, rd_valid, busy, done, err}, 0);
    chk("rst_data", {rd_bank_en, rd_addr, rd_coord}, 0);
    rstn = 1;
    vecs[0] = '{128, 4, 7, 0, -1, 0, 0};
    vecs[1] = '{128, 4, 7, 1, -1, 1, 0};
    vecs[2] = '{32, 4, 7, 0, -1, 0, 1};
    vecs[3] = '{128, 4, 7, 0, -1, 0, 0};
    vecs[4] = '{128, 0, 7, 0, -1, 0, 1};
    vecs[5] = '{128, 4, 2, 0, -1, 0, 1};
    vecs[6] = '{64, 3, 3, 1, -1, 0, 0};
    vecs[7] = '{192, 2, 11, 1, -1, 0, 0};
    vecs[8] = '{128, 4, 7, 0, 10, 0, 0};
    vecs[9] = '{640, 20, 12, 0, -1, 0, 0};
    for (int i = 0; i < 10; i++) begin
      run_job(vecs[i]);
      if (i == 0) begin
        chk("first_en", got[0].en, 5'b00111);
        chk("first_addr", got[0].addr, 0);
        chk("x0_3_en", got[24].en, 5'b11001);
        chk("x0_3_bank0", got[24].addr[0+:BA], 8);
        chk("x0_3_bank34", got[24].addr[3*BA+:2*BA], 0);
        chk("x0_3_coord", got[24].coord, {8'd0, 8'd0, 8'd3});
      end
    end
    run_job('{128, 4, 7, 0, -1, 0, 0});
    dshape = {16'd7, 16'd4, 16'd128};
    ld_done = 1;
    rd_ready = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    begin
      int seen = 0;
      for (int cyc = 0; cyc < 50 && seen < 5; cyc++) begin
        if (rd_valid) seen++;
        @(negedge clk);
      end
      chk("rst_reach_read", seen, 5);
    end
    rstn = 0;
    @(negedge clk);
    chk("midrst_ctrl", {clr, rd_valid, busy, done, err}, 0);
    chk("midrst_data", {rd_bank_en, rd_addr, rd_coord}, 0);
    rstn = 1;
    ld_done = 0;
    rd_ready = 0;
    run_job('{128, 4, 7, 1, -1, 0, 0});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
